// File: rtl/mux_tree_pipe_pkg.sv
// mux_tree_pipe_pkg: default sizing, per-stage record and level-offset helper for mux_tree_pipe
package mux_tree_pipe_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int SEL_BITS_DEF = 3;
  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic [SEL_BITS_DEF-1:0] sel;
    logic valid;
  } stage_rec_t;
  // Level k's candidates sit at this offset of the flattened tree (inputs first, root last)
  function automatic int lvl_off(int num_in, int k);
    return 2 * num_in - 2 * (num_in >> k);
  endfunction
endpackage

// File: rtl/mux_tree_pipe_if.sv
// mux_tree_pipe_if: valid/ready input and output channels of mux_tree_pipe
interface mux_tree_pipe_if import mux_tree_pipe_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_BITS = SEL_BITS_DEF
);
  localparam int NUM_IN = 2 ** SEL_BITS;
  logic [NUM_IN-1:0][WIDTH-1:0] in_data;
  logic [SEL_BITS-1:0] in_sel;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master(output in_data, in_sel, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave(input in_data, in_sel, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/mux_tree_pipe_stage.sv
// mux_pipe_stage: one 2:1 reduction level with its pipeline register and stall logic
module mux_pipe_stage #(
  parameter int WIDTH = 64,
  parameter int N = 8,
  parameter int SB = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic [N-1:0][WIDTH-1:0] in_data,
  input  logic [SB-1:0] in_sel,
  input  logic in_valid,
  input  logic next_load,
  output logic load,
  output logic [N/2-1:0][WIDTH-1:0] out_data,
  output logic [SB-1:0] out_sel,
  output logic out_valid
);
  typedef struct packed {
    logic [N/2-1:0][WIDTH-1:0] data;
    logic [SB-1:0] sel;
    logic valid;
  } rec_t;
  rec_t r;
  logic [N/2-1:0][WIDTH-1:0] red;
  for (genvar j = 0; j < N / 2; j++) begin : g_pair
    assign red[j] = in_sel[0] ? in_data[2*j+1] : in_data[2*j];
  end
  assign load = !r.valid || next_load;
  // Select is shifted down so every level consumes bit 0 of what it receives
  always_ff @(posedge clk) begin
    if (!reset_n) r <= '0;
    else if (clr) r.valid <= 1'b0;
    else if (load) r <= '{data: red, sel: in_sel >> 1, valid: in_valid};
  end
  assign out_data = r.data;
  assign out_sel = r.sel;
  assign out_valid = r.valid;
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined 2**SEL_BITS:1 mux tree, one register per level, valid/ready flow control.
// Define MUX_TREE_PIPE_FLUSH_EN to add a flush port that empties the pipeline.
module mux_tree_pipe import mux_tree_pipe_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_BITS = SEL_BITS_DEF
) (
  input logic clk,
  input logic reset_n,
`ifdef MUX_TREE_PIPE_FLUSH_EN
  input logic flush,
`endif
  mux_tree_pipe_if.slave bus
);
  localparam int NUM_IN = 2 ** SEL_BITS;
  wire logic [2*NUM_IN-2:0][WIDTH-1:0] node;
  wire logic [SEL_BITS:0][SEL_BITS-1:0] sel;
  wire logic [SEL_BITS:0] vld;
  wire logic [SEL_BITS:0] load;
  logic clr;
`ifdef MUX_TREE_PIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif
  assign node[NUM_IN-1:0] = bus.in_data;
  assign sel[0] = bus.in_sel;
  assign vld[0] = bus.in_valid;
  assign load[SEL_BITS] = !vld[SEL_BITS] || bus.out_ready;
  for (genvar k = 0; k < SEL_BITS; k++) begin : g_lvl
    localparam int NK = NUM_IN >> k;
    localparam int OFF = lvl_off(NUM_IN, k);
    mux_pipe_stage #(.WIDTH(WIDTH), .N(NK), .SB(SEL_BITS)) u_stage (
      .clk(clk),
      .reset_n(reset_n),
      .clr(clr),
      .in_data(node[OFF +: NK]),
      .in_sel(sel[k]),
      .in_valid(vld[k]),
      .next_load(load[k+1]),
      .load(load[k]),
      .out_data(node[OFF+NK +: NK/2]),
      .out_sel(sel[k+1]),
      .out_valid(vld[k+1])
    );
  end
  assign bus.in_ready = load[0] && !clr;
  assign bus.out_data = node[2*NUM_IN-2];
  assign bus.out_valid = vld[SEL_BITS];
  logic unused_sel;
  assign unused_sel = ^sel[SEL_BITS];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: scoreboard bench for mux_tree_pipe; a 64-bit instance for the
// functional scenarios and a 1-bit instance for the exhaustive sweep.
module tb_mux_tree_pipe;
  localparam int W = 64;
  localparam int SB = 3;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] q[$];
  logic q1[$];
  logic [N-1:0][W-1:0] pat;
  mux_tree_pipe_if #(.WIDTH(W), .SEL_BITS(SB)) bus ();
  mux_tree_pipe_if #(.WIDTH(1), .SEL_BITS(SB)) bus1 ();
`ifdef MUX_TREE_PIPE_FLUSH_EN
  logic flush = 1'b0;
  logic flush1 = 1'b0;
`endif
  mux_tree_pipe #(.WIDTH(W), .SEL_BITS(SB)) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef MUX_TREE_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .bus(bus)
  );
  mux_tree_pipe #(.WIDTH(1), .SEL_BITS(SB)) dut1 (
    .clk(clk),
    .reset_n(reset_n),
`ifdef MUX_TREE_PIPE_FLUSH_EN
    .flush(flush1),
`endif
    .bus(bus1)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_vec++;
    if (bus.out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_vec++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_w1: got valid %b ready %b want 0 1", bus1.out_valid, bus1.in_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.in_data = pat;
    bus.in_sel = 3'd5;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b want 1", bus.in_ready); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_vec++;
      if (c == 3) begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== pat[5]) begin
          n_err++; $display("FAIL single_result: got %b/%h want 1/%h", bus.out_valid, bus.out_data, pat[5]);
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_err++; $display("FAIL single_pulse: cycle %0d got out_valid %b want 0", c, bus.out_valid);
      end
    end
  endtask

  task automatic test_stream();
    int first = -1;
    int got = 0;
    q.delete();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bus.in_valid = c < 8;
      bus.in_sel = 3'(c);
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) begin
        n_vec++;
        if (q.size() == 0 || bus.out_data !== q[0]) begin
          n_err++; $display("FAIL stream_data: got %h want %h", bus.out_data, q.size() != 0 ? q[0] : 'x);
        end
        if (q.size() != 0) q.delete(0);
        if (first < 0) first = c;
        got++;
        n_vec++;
        if (c != first + got - 1) begin n_err++; $display("FAIL stream_gap: result %0d at cycle %0d want %0d", got, c, first + got - 1); end
      end
      if (bus.in_valid) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready: cycle %0d got %b want 1", c, bus.in_ready); end
        q.push_back(pat[c]);
      end
    end
    n_vec++;
    if (first != 3 || got != 8) begin n_err++; $display("FAIL stream_count: got first %0d count %0d want 3 8", first, got); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0][W-1:0] pr;
    logic [W-1:0] held = '0;
    bit have = 1'b0;
    int acc = 0;
    int got = 0;
    for (int i = 0; i < N; i++) pr[i] = {$urandom, $urandom};
    q.delete();
    bus.in_data = pr;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_sel = 3'(acc);
      #1;
      if (bus.in_ready) begin q.push_back(pr[acc]); acc++; end
      if (bus.out_valid) begin
        if (!have) begin held = bus.out_data; have = 1'b1; end
        else begin
          n_vec++;
          if (bus.out_data !== held) begin n_err++; $display("FAIL bp_stall: got %h want %h", bus.out_data, held); end
        end
      end
    end
    n_vec++;
    if (acc != 3) begin n_err++; $display("FAIL bp_accepted: got %0d want 3", acc); end
    n_vec++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = acc < 4;
      bus.in_sel = 3'(acc);
      #1;
      if (c == 0) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
      end
      if (bus.out_valid) begin
        n_vec++;
        if (q.size() == 0 || bus.out_data !== q[0]) begin
          n_err++; $display("FAIL bp_order: got %h want %h", bus.out_data, q.size() != 0 ? q[0] : 'x);
        end
        if (q.size() != 0) q.delete(0);
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin q.push_back(pr[acc]); acc++; end
    end
    n_vec++;
    if (got != 4 || q.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d results %0d left want 4 0", got, q.size()); end
  endtask

  task automatic test_reset_mid();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus.in_data = pat;
      bus.in_sel = 3'(c);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale: cycle %0d got out_valid %b data %h want 0", c, bus.out_valid, bus.out_data); end
    end
  endtask

`ifdef MUX_TREE_PIPE_FLUSH_EN
  task automatic test_flush();
    int acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.in_data = pat;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_sel = 3'(acc);
      #1;
      if (bus.in_ready) acc++;
    end
    @(negedge clk);
    flush = 1'b1;
    bus.in_sel = 3'd7;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear: got %b want 0", bus.out_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost: got data %h want no output", bus.out_data); end
    end
  endtask
`endif

  task automatic test_exhaustive();
    int sent = 0;
    int got = 0;
    logic [10:0] v;
    q1.delete();
    for (int c = 0; c < 6000 && got < 2048; c++) begin
      @(negedge clk);
      v = 11'(sent);
      bus1.out_ready = $urandom_range(3) != 0;
      bus1.in_valid = sent < 2048;
      bus1.in_sel = v[10:8];
      bus1.in_data = v[7:0];
      #1;
      if (bus1.out_valid && bus1.out_ready) begin
        n_vec++;
        if (q1.size() == 0 || bus1.out_data !== q1[0]) begin
          n_err++; $display("FAIL exh_data: result %0d got %b want %b", got, bus1.out_data, q1.size() != 0 ? q1[0] : 1'bx);
        end
        if (q1.size() != 0) q1.delete(0);
        got++;
      end
      if (bus1.in_valid && bus1.in_ready) begin q1.push_back(v[v[10:8]]); sent++; end
    end
    bus1.in_valid = 1'b0;
    n_vec++;
    if (got != 2048) begin n_err++; $display("FAIL exh_count: got %0d results want 2048", got); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) pat[i] = 64'h1111_0000_0000_0000 * W'(i) + W'(i);
    bus.in_data = '0;
    bus.in_sel = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus1.in_data = '0;
    bus1.in_sel = '0;
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_mid();
`ifdef MUX_TREE_PIPE_FLUSH_EN
    test_flush();
`endif
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
